// File: rtl/motor_pkg.sv
// Shared encodings for the line-follower drive path: steering commands,
// H-bridge input patterns and the wheel direction type.
package motor_pkg;

  localparam logic [1:0] CMD_STOP     = 2'b00;
  localparam logic [1:0] CMD_LEFT     = 2'b01;
  localparam logic [1:0] CMD_RIGHT    = 2'b10;
  localparam logic [1:0] CMD_STRAIGHT = 2'b11;

  localparam logic [1:0] IN_FWD   = 2'b10;
  localparam logic [1:0] IN_REV   = 2'b01;
  localparam logic [1:0] IN_COAST = 2'b00;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  // A stopped wheel coasts regardless of its remembered direction.
  function automatic logic [1:0] bridge_in(input dir_e dir, input logic running);
    if (!running) return IN_COAST;
    return (dir == DIR_REV) ? IN_REV : IN_FWD;
  endfunction

endpackage

// File: rtl/motor_wheel_ramp.sv
// Per-wheel duty/direction ramp: steps duty toward the target once per PWM
// period and inserts a zero-duty period before any direction reversal.
module motor_wheel_ramp
  import motor_pkg::*;
#(
  parameter int PWM_BITS  = 10,
  parameter int RAMP_STEP = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                boundary,
  input  dir_e                target_dir,
  input  logic [PWM_BITS-1:0] target_duty,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          h_in
);

  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);

  dir_e                dir;
  dir_e                dir_next;
  logic [PWM_BITS-1:0] duty_next;

  // Differences are compared against STEP before any add/subtract, so the
  // result can neither wrap nor overshoot the target.
  always_comb begin
    duty_next = duty;
    dir_next  = dir;
    if (boundary) begin
      if (dir != target_dir) begin
        if (duty == '0) begin
          dir_next = target_dir;
        end else if (duty > STEP) begin
          duty_next = duty - STEP;
        end else begin
          duty_next = '0;
        end
      end else if (duty < target_duty) begin
        if ((target_duty - duty) > STEP) begin
          duty_next = duty + STEP;
        end else begin
          duty_next = target_duty;
        end
      end else if (duty > target_duty) begin
        if ((duty - target_duty) > STEP) begin
          duty_next = duty - STEP;
        end else begin
          duty_next = target_duty;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty <= '0;
      dir  <= DIR_FWD;
    end else begin
      duty <= duty_next;
      dir  <= dir_next;
    end
  end

  assign h_in = bridge_in(dir, duty != '0);

endmodule

// File: rtl/motor_drive.sv
// Two-wheel motor driver: debounces the steering command, decodes per-wheel
// targets, runs the shared PWM counter and produces registered PWM enables.
module motor_drive
  import motor_pkg::*;
#(
  parameter int PWM_BITS      = 10,
  parameter int DUTY_STRAIGHT = 768,
  parameter int DUTY_TURN_OUT = 768,
  parameter int DUTY_TURN_IN  = 256,
  parameter int RAMP_STEP     = 32,
  parameter int HOLD_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] state,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic [1:0] left_in,
  output logic [1:0] right_in,
  output logic [1:0] cmd_active
);

  localparam int                  HOLD_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
  localparam logic [PWM_BITS-1:0] D_STRAIGHT = PWM_BITS'(DUTY_STRAIGHT);
  localparam logic [PWM_BITS-1:0] D_OUT      = PWM_BITS'(DUTY_TURN_OUT);
  localparam logic [PWM_BITS-1:0] D_IN       = PWM_BITS'(DUTY_TURN_IN);

  logic [1:0]          last_sample;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_next;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                boundary;
  dir_e                left_tdir;
  dir_e                right_tdir;
  logic [PWM_BITS-1:0] left_tduty;
  logic [PWM_BITS-1:0] right_tduty;
  logic [PWM_BITS-1:0] left_duty;
  logic [PWM_BITS-1:0] right_duty;

  always_comb begin
    hold_next = HOLD_W'(1);
    if (state == last_sample) begin
      hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
    end
  end

  // The command is adopted on the edge where the run of equal samples
  // reaches HOLD_CYCLES; once saturated it simply keeps the same value.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_sample <= CMD_STOP;
      hold_cnt    <= '0;
      cmd_active  <= CMD_STOP;
    end else begin
      last_sample <= state;
      hold_cnt    <= hold_next;
      if (hold_next == HOLD_MAX) begin
        cmd_active <= state;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign boundary = (pwm_cnt == '1);

  always_comb begin
    left_tdir   = DIR_FWD;
    right_tdir  = DIR_FWD;
    left_tduty  = '0;
    right_tduty = '0;
    case (cmd_active)
      CMD_STRAIGHT: begin
        left_tduty  = D_STRAIGHT;
        right_tduty = D_STRAIGHT;
      end
      CMD_LEFT: begin
        left_tdir   = DIR_REV;
        left_tduty  = D_IN;
        right_tduty = D_OUT;
      end
      CMD_RIGHT: begin
        left_tduty  = D_OUT;
        right_tdir  = DIR_REV;
        right_tduty = D_IN;
      end
      default: ;
    endcase
  end

  motor_wheel_ramp #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_left (
    .clk         (clk),
    .reset       (reset),
    .boundary    (boundary),
    .target_dir  (left_tdir),
    .target_duty (left_tduty),
    .duty        (left_duty),
    .h_in        (left_in)
  );

  motor_wheel_ramp #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_right (
    .clk         (clk),
    .reset       (reset),
    .boundary    (boundary),
    .target_dir  (right_tdir),
    .target_duty (right_tduty),
    .duty        (right_duty),
    .h_in        (right_in)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      left_pwm  <= 1'b0;
      right_pwm <= 1'b0;
    end else begin
      left_pwm  <= (pwm_cnt < left_duty);
      right_pwm <= (pwm_cnt < right_duty);
    end
  end

endmodule

// File: tb/tb_motor_drive.sv
// Bench for motor_drive with a small PWM configuration: a phase table with
// hand-derived end states, targeted corner sequences and a random run.
module tb_motor_drive;
  import motor_pkg::*;

  localparam int PB     = 4;
  localparam int PERIOD = 16;
  localparam int STEP   = 4;
  localparam int D_FULL = 12;
  localparam int D_IN   = 4;
  localparam int HOLD   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state = 2'b00;
  logic       left_pwm, right_pwm;
  logic [1:0] left_in, right_in, cmd_active;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  int         m_cnt;
  int         m_cmd;
  int         m_duty [2];
  int         m_dir  [2];
  int         m_pwm  [2];
  logic [1:0] m_hist [$];

  typedef struct {
    logic       rst;
    logic [1:0] st;
    int         cycles;
    logic [1:0] exp_cmd;
    logic [1:0] exp_lin;
    logic [1:0] exp_rin;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  motor_drive #(
    .PWM_BITS      (PB),
    .DUTY_STRAIGHT (D_FULL),
    .DUTY_TURN_OUT (D_FULL),
    .DUTY_TURN_IN  (D_IN),
    .RAMP_STEP     (STEP),
    .HOLD_CYCLES   (HOLD)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .left_pwm   (left_pwm),
    .right_pwm  (right_pwm),
    .left_in    (left_in),
    .right_in   (right_in),
    .cmd_active (cmd_active)
  );

  task automatic model_target(input int cmd, input int w, output int tdir, output int tduty);
    tdir = 0;
    tduty = 0;
    case (cmd)
      3: tduty = D_FULL;
      1: if (w == 0) begin tdir = 1; tduty = D_IN; end else tduty = D_FULL;
      2: if (w == 1) begin tdir = 1; tduty = D_IN; end else tduty = D_FULL;
      default: ;
    endcase
  endtask

  // Behavioural view: a command is live once the last HOLD samples agree;
  // each wheel moves once per period by the ramp rules using integer math.
  task automatic model_step(input logic rst, input logic [1:0] st);
    int tdir, tduty;
    bit same;
    if (rst) begin
      m_cnt = 0;
      m_cmd = 0;
      for (int w = 0; w < 2; w++) begin
        m_duty[w] = 0;
        m_dir[w] = 0;
        m_pwm[w] = 0;
      end
      m_hist.delete();
      return;
    end
    for (int w = 0; w < 2; w++) m_pwm[w] = (m_cnt < m_duty[w]) ? 1 : 0;
    if (m_cnt == PERIOD - 1) begin
      for (int w = 0; w < 2; w++) begin
        model_target(m_cmd, w, tdir, tduty);
        if (m_dir[w] != tdir) begin
          if (m_duty[w] > 0) m_duty[w] = (m_duty[w] > STEP) ? m_duty[w] - STEP : 0;
          else m_dir[w] = tdir;
        end else if (m_duty[w] < tduty) begin
          m_duty[w] = (m_duty[w] + STEP > tduty) ? tduty : m_duty[w] + STEP;
        end else begin
          m_duty[w] = (m_duty[w] - STEP < tduty) ? tduty : m_duty[w] - STEP;
        end
      end
    end
    m_cnt = (m_cnt + 1) % PERIOD;
    m_hist.push_back(st);
    if (m_hist.size() > HOLD) void'(m_hist.pop_front());
    if (m_hist.size() == HOLD) begin
      same = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] != st) same = 1'b0;
      if (same) m_cmd = int'(st);
    end
  endtask

  function automatic logic [1:0] model_in(input int w);
    if (m_duty[w] == 0) return IN_COAST;
    return (m_dir[w] == 1) ? IN_REV : IN_FWD;
  endfunction

  task automatic checkOutput(input string name);
    logic [7:0] got, exp;
    got = {cmd_active, left_pwm, right_pwm, left_in, right_in};
    exp = {2'(m_cmd), 1'(m_pwm[0]), 1'(m_pwm[1]), model_in(0), model_in(1)};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got cmd=%b lpwm=%b rpwm=%b lin=%b rin=%b, expected cmd=%b lpwm=%b rpwm=%b lin=%b rin=%b",
               name, cycle, got[7:6], got[5], got[4], got[3:2], got[1:0],
               exp[7:6], exp[5], exp[4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, cycle, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [1:0] st);
    reset = rst;
    state = st;
    @(posedge clk);
    model_step(rst, st);
    cycle++;
    #1;
    checkOutput("model");
  endtask

  initial begin
    int highs_l, highs_r, waited, run, rst_sel;
    logic [1:0] rs;

    tbl[0] = '{1'b1, 2'b00,   2, 2'b00, IN_COAST, IN_COAST};
    tbl[1] = '{1'b0, 2'b00,  20, 2'b00, IN_COAST, IN_COAST};
    tbl[2] = '{1'b0, 2'b11,  80, 2'b11, IN_FWD,   IN_FWD};
    tbl[3] = '{1'b0, 2'b01,   2, 2'b11, IN_FWD,   IN_FWD};
    tbl[4] = '{1'b0, 2'b11,  16, 2'b11, IN_FWD,   IN_FWD};
    tbl[5] = '{1'b0, 2'b01, 100, 2'b01, IN_REV,   IN_FWD};
    tbl[6] = '{1'b0, 2'b10, 150, 2'b10, IN_FWD,   IN_REV};
    tbl[7] = '{1'b0, 2'b00, 100, 2'b00, IN_COAST, IN_COAST};

    model_step(1'b1, 2'b00);
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < tbl[p].cycles; c++) applyStimulus(tbl[p].rst, tbl[p].st);
      checkValue($sformatf("phase%0d_cmd", p), int'(cmd_active), int'(tbl[p].exp_cmd));
      checkValue($sformatf("phase%0d_left_in", p), int'(left_in), int'(tbl[p].exp_lin));
      checkValue($sformatf("phase%0d_right_in", p), int'(right_in), int'(tbl[p].exp_rin));
    end

    // Acceptance latency from a settled stop
    applyStimulus(1'b0, 2'b11);
    applyStimulus(1'b0, 2'b11);
    checkValue("latency_early", int'(cmd_active), 0);
    applyStimulus(1'b0, 2'b11);
    checkValue("latency_exact", int'(cmd_active), 3);

    // Steady straight: 12 high cycles out of every 16
    for (int c = 0; c < 80; c++) applyStimulus(1'b0, 2'b11);
    highs_l = 0;
    highs_r = 0;
    for (int c = 0; c < PERIOD; c++) begin
      applyStimulus(1'b0, 2'b11);
      highs_l += int'(left_pwm);
      highs_r += int'(right_pwm);
    end
    checkValue("steady_left_highs", highs_l, 12);
    checkValue("steady_right_highs", highs_r, 12);

    // Short glitch must not reach the accepted command
    applyStimulus(1'b0, 2'b01);
    applyStimulus(1'b0, 2'b01);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 2'b11);
    checkValue("glitch_cmd", int'(cmd_active), 3);
    checkValue("glitch_left_in", int'(left_in), int'(IN_FWD));

    // Reset in the middle of a ramp
    applyStimulus(1'b1, 2'b00);
    waited = 0;
    while (m_duty[0] != 8 && waited < 200) begin
      applyStimulus(1'b0, 2'b11);
      waited++;
    end
    checkValue("ramp_reached_8", m_duty[0], 8);
    applyStimulus(1'b1, 2'b11);
    checkValue("rst_cmd", int'(cmd_active), 0);
    checkValue("rst_pwm", int'({left_pwm, right_pwm}), 0);
    checkValue("rst_in", int'({left_in, right_in}), 0);
    checkValue("rst_counter", int'(u_dut.pwm_cnt), 0);

    // Randomized command runs with occasional resets
    while (cycle < 4000) begin
      rs = 2'($urandom_range(0, 3));
      run = $urandom_range(1, 40);
      rst_sel = $urandom_range(0, 99);
      if (rst_sel < 2) applyStimulus(1'b1, rs);
      for (int c = 0; c < run; c++) applyStimulus(1'b0, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
